ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
// - Shares one single-port synchronous RAM between NUM_REQ requesters.
// - Each requester has a valid/ready command port and a response-valid strobe.
// - Round-robin arbitration with bounded burst; sits between client logic and the RAM instance.
// - Drives the RAM's clk-synchronous enable/wr_en/address/data_in pins.
// - RAM read data returns one cycle after the RAM samples the command.
// PARAMETERS
// - NUM_REQ    2  number of requesters (2..8)
// - WIDTH      8  data width, equal to the RAM's WIDTH
// - DEPTH      4  RAM address width in bits, equal to the RAM's DEPTH
// - MAX_BURST  4  maximum consecutive grants to one requester while others wait (1..15)
// PORTS
// - clk          in   1              system clock, rising edge
// - reset        in   1              asynchronous, active-high reset
// - req_valid    in   NUM_REQ        command valid, one bit per requester
// - req_ready    out  NUM_REQ        command accepted this cycle (one-hot or 0)
// - req_wr       in   NUM_REQ        1 = write, 0 = read
// - req_addr     in   NUM_REQ*DEPTH  packed addresses; requester i at [i*DEPTH +: DEPTH]
// - req_wdata    in   NUM_REQ*WIDTH  packed write data
// - rsp_valid    out  NUM_REQ        response strobe, one-hot or 0
// - rsp_data     out  WIDTH          read data, valid when any rsp_valid bit is set
// - ram_enable   out  1              to RAM enable
// - ram_wr_en    out  1              to RAM wr_en
// - ram_address  out  DEPTH          to RAM address
// - ram_data_in  out  WIDTH          to RAM data_in
// - ram_data_out in   WIDTH          from RAM data_out
// BEHAVIOUR
// - Reset (async assert, sync release) clears:
//   - req_ready, rsp_valid, ram_enable, ram_wr_en, ram_address, ram_data_in, rsp_data to 0
//   - rr pointer to 0, burst count to 0, response pipeline to empty
// - Grant is combinational from req_valid, rr pointer and burst state; req_ready = grant.
//   - req_ready never depends on anything other than req_valid and registered state.
// - Handshake: a command is accepted at the edge where req_valid[i] & req_ready[i].
//   - The requester holds valid/wr/addr/wdata stable until accepted.
// - At most one acceptance per cycle: a full-throughput pipeline, no idle bubbles.
// - Accept at edge E0:
//   - ram_enable/ram_wr_en/ram_address/ram_data_in are registered at E0.
//   - The RAM samples them at E1.
// - Cycle with no acceptance: ram_enable=0, ram_wr_en=0; address and data hold their last value.
// - Read response: rsp_valid[i] is registered at E1 and high for exactly the cycle E1..E2.
//   - rsp_data = ram_data_out (combinational) during that cycle, otherwise 0.
//   - Total latency is 2 edges from acceptance to rsp_valid.
// - Write response: none, unless the RAM_ARB_WRACK_EN macro is defined (see CONFIGURATION).
// - Round-robin: search starts at rr pointer, wrapping from NUM_REQ-1 to 0.
//   - After granting i, the rr pointer becomes (i+1) mod NUM_REQ, unless burst hold applies.
// - Burst hold:
//   - If the last-granted requester is still valid and burst count < MAX_BURST, it is granted again; the count increments.
//   - When the count reaches MAX_BURST and another requester is valid, rotate and reset the count to 1.
//   - A lone requester is never throttled: its count saturates.
// - Simultaneous requests from all requesters with MAX_BURST=1 give strict alternation.
// - Read and write to the same address in back-to-back cycles: RAM order is preserved.
//   - The later read sees the written data.
// - Reset mid-operation: in-flight responses are discarded and no rsp_valid fires after reset.
// CONFIGURATION
// - RAM_ARB_WRACK_EN defined: an accepted write also raises rsp_valid[i] at E1 with rsp_data=0.
// - RAM_ARB_WRACK_EN undefined: writes produce no rsp_valid; only reads respond.
// STRUCTURE
// - Package ram_arbiter_pkg holds:
//   - typedef arb_state_t {ARB_IDLE, ARB_GRANT, ARB_HOLD} (tracks burst ownership)
//   - function rr_pick(valid, ptr) returning a one-hot grant
//   - localparam BURST_W = $clog2(MAX_BURST+1)
// - One sub-module rr_grant (combinational round-robin priority picker), reused by later arbiters.
// - The top holds the rr pointer, burst counter, state, the RAM command register and the response shift register.
// TESTING
// - Reset mid-read: accept a read, assert reset at E1 -> rsp_valid stays 0; all outputs read 0.
// - Single read: data.dat preload, req 0 reads addr 3 -> rsp_valid[0] exactly 2 edges later, rsp_data = mem[3].
// - Write then read: req 1 writes 8'hff to addr 5, next cycle req 0 reads addr 5 -> rsp_data 8'hff.
// - Contention, MAX_BURST=4: both valid continuously for 16 cycles -> grant order 0,0,0,0,1,1,1,1,0...
//   - rsp_valid count per requester = 8.
// - Lone requester: req 1 only, 10 back-to-back reads -> 10 consecutive accepts, 10 responses, no bubbles.
// - Build with RAM_ARB_WRACK_EN: write by req 0 -> rsp_valid[0] 2 edges later.
//   - Without the macro -> rsp_valid stays 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter and its round-robin picker.
package ram_arbiter_pkg;

    localparam int MAX_REQ       = 8;
    localparam int MAX_BURST_LIM = 15;
    localparam int BURST_W       = $clog2(MAX_BURST_LIM + 1);
    localparam int PTR_W         = $clog2(MAX_REQ);
    localparam int IDX_W         = PTR_W + 1;

    // Burst ownership: no owner, owner below its burst limit, owner at its limit.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_HOLD
    } arb_state_t;

    // One-hot grant of the first valid requester at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input logic [IDX_W-1:0]   n
    );
        logic [MAX_REQ-1:0] grant;
        logic [IDX_W-1:0]   idx;
        grant = '0;
        // Walk from farthest to nearest so the nearest valid requester wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= n)
                idx = idx - n;
            if ((IDX_W'(k) < n) && valid[idx[PTR_W-1:0]])
                grant = MAX_REQ'(1) << idx;
        end
        return grant;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_grant.sv
// Combinational round-robin priority picker over N requesters, starting at ptr.
module rr_grant
    import ram_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
    end

    assign pick = rr_pick(valid_ext, ptr, IDX_W'(N));

    // Bits at or above N are always zero; folding them keeps every bit used.
    always_comb begin
        grant = '0;
        for (int i = 0; i < MAX_REQ; i++)
            grant[i % N] = grant[i % N] | pick[i];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port synchronous RAM.
// Define RAM_ARB_WRACK_EN to make accepted writes return a response strobe too.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [NUM_REQ*DEPTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     ram_enable,
    output logic                     ram_wr_en,
    output logic [DEPTH-1:0]         ram_address,
    output logic [WIDTH-1:0]         ram_data_in,
    input  logic [WIDTH-1:0]         ram_data_out
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    arb_state_t           state, state_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [NUM_REQ-1:0]   owner_oh, owner_nxt;
    logic [BURST_W-1:0]   burst_cnt, cnt_nxt;

    logic [NUM_REQ-1:0]   rr_gnt;
    logic [NUM_REQ-1:0]   gnt;
    logic                 owner_vld;
    logic                 others_vld;
    logic                 hold;

    logic                 sel_wr;
    logic [DEPTH-1:0]     sel_addr;
    logic [WIDTH-1:0]     sel_wdata;
    logic [NUM_REQ-1:0]   rsp_sel;

    logic [NUM_REQ-1:0]   pend_rsp;
    logic                 pend_rd;
    logic                 rsp_rd;

    rr_grant #(
        .N(NUM_REQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (rr_gnt)
    );

    // Arbitration state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner_oh  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner_oh  <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Grant and next-state: the owner keeps the port while its burst allows,
    // or indefinitely while nobody else is asking.
    always_comb begin
        hold       = 1'b0;
        owner_vld  = |(req_valid & owner_oh);
        others_vld = |(req_valid & ~owner_oh);
        state_nxt  = ARB_IDLE;
        cnt_nxt    = '0;
        owner_nxt  = owner_oh;
        ptr_nxt    = ptr;

        case (state)
            ARB_GRANT: hold = owner_vld;
            ARB_HOLD:  hold = owner_vld && !others_vld;
            default:   hold = 1'b0;
        endcase

        gnt = hold ? owner_oh : rr_gnt;

        if (hold) begin
            cnt_nxt = (state == ARB_GRANT) ? burst_cnt + BURST_W'(1) : burst_cnt;
        end else if (|gnt) begin
            cnt_nxt = BURST_W'(1);
        end

        if (|gnt) begin
            owner_nxt = gnt;
            state_nxt = (cnt_nxt == BURST_MAX) ? ARB_HOLD : ARB_GRANT;
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt[i])
                    ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    assign req_ready = gnt;

    // Command mux from the granted requester.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*DEPTH +: DEPTH];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rsp_sel = '0;
`ifdef RAM_ARB_WRACK_EN
        rsp_sel = gnt;
`else
        if (!sel_wr)
            rsp_sel = gnt;
`endif
    end

    // RAM command register; address and data hold on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_enable  <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else begin
            ram_enable <= |gnt;
            ram_wr_en  <= (|gnt) & sel_wr;
            if (|gnt) begin
                ram_address <= sel_addr;
                ram_data_in <= sel_wdata;
            end
        end
    end

    // Two-stage response pipe lined up with the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rsp  <= '0;
            pend_rd   <= 1'b0;
            rsp_valid <= '0;
            rsp_rd    <= 1'b0;
        end else begin
            pend_rsp  <= rsp_sel;
            pend_rd   <= (|gnt) & ~sel_wr;
            rsp_valid <= pend_rsp;
            rsp_rd    <= pend_rd;
        end
    end

    assign rsp_data = rsp_rd ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter against a grant/response reference model.
module tb_ram_arbiter;

    localparam int NR = 2;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int MB = 4;
`ifdef RAM_ARB_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_ready, req_wr, rsp_valid;
    logic [NR*D-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic [W-1:0]    rsp_data, ram_data_in, ram_q;
    logic            ram_enable, ram_wr_en;
    logic [D-1:0]    ram_address;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_enable(ram_enable), .ram_wr_en(ram_wr_en),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_q)
    );

    function automatic logic [W-1:0] init_val(int a);
        return W'(a * 37 + 11);
    endfunction

    // Single-port synchronous RAM, preloaded on its first clock.
    logic [W-1:0] ram_mem [1<<D];
    logic         ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < (1 << D); i++) ram_mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (ram_enable) begin
            if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
            else           ram_q <= ram_mem[ram_address];
        end
    end

    // Reference model: last grantee, its consecutive-grant count, rotation
    // start, shadow memory and expected responses keyed by cycle.
    int           m_last, m_cnt, m_ptr, cyc;
    logic [W-1:0] m_mem [1<<D];
    logic [NR-1:0] exp_v [64];
    logic [W-1:0]  exp_d [64];

    task automatic model_reset();
        m_last = -1; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < 64; i++) begin exp_v[i] = '0; exp_d[i] = '0; end
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic set_cmd(int i, bit wr, int addr, int data);
        req_wr[i] = wr;
        req_addr[i*D +: D] = D'(addr);
        req_wdata[i*W +: W] = W'(data);
    endtask

    // Samples DUT and model for the current cycle, then advances one edge.
    task automatic run_cycle(output logic [NR-1:0] g_rdy, output logic [NR-1:0] e_rdy,
                             output logic [NR-1:0] g_rv,  output logic [NR-1:0] e_rv,
                             output logic [W-1:0]  g_rd,  output logic [W-1:0]  e_rd);
        int pick, a, slot;
        bit others;
        @(negedge clk);
        pick = -1; others = 0;
        for (int i = 0; i < NR; i++) if (i != m_last && req_valid[i]) others = 1;
        if (m_last >= 0 && req_valid[m_last] && (m_cnt < MB || !others)) pick = m_last;
        else for (int k = 0; k < NR; k++)
            if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
        slot  = cyc % 64;
        e_rdy = (pick >= 0) ? (NR'(1) << pick) : '0;
        e_rv  = exp_v[slot]; e_rd = exp_d[slot];
        g_rdy = req_ready;   g_rv = rsp_valid; g_rd = rsp_data;
        exp_v[slot] = '0; exp_d[slot] = '0;
        if (pick >= 0) begin
            a = int'(req_addr[pick*D +: D]);
            slot = (cyc + 2) % 64;
            if (req_wr[pick]) begin
                m_mem[a] = req_wdata[pick*W +: W];
                if (WRACK) exp_v[slot] = NR'(1) << pick;
            end else begin
                exp_v[slot] = NR'(1) << pick;
                exp_d[slot] = m_mem[a];
            end
            m_cnt = (pick == m_last) ? ((m_cnt < MB) ? m_cnt + 1 : m_cnt) : 1;
            m_ptr = (pick + 1) % NR;
        end
        m_last = pick;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if ({ram_enable, ram_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_ram_ctl got %b want 00", {ram_enable, ram_wr_en}); end
        checks++; if ({ram_address, ram_data_in, rsp_data} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", ram_address, ram_data_in, rsp_data); end
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        req_valid = 2'b01; set_cmd(0, 1'b0, 3, 0);
        for (int k = 0; k < 4; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            req_valid = '0;
            checks++; if (g_rdy !== e_rdy) begin errors++; $display("FAIL single_ready c%0d got %b want %b", k, g_rdy, e_rdy); end
            checks++; if ({g_rv, g_rd} !== {e_rv, e_rd}) begin errors++; $display("FAIL single_rsp c%0d got %b/%h want %b/%h", k, g_rv, g_rd, e_rv, e_rd); end
            if (k == 2) begin
                checks++; if ({g_rv, g_rd} !== {2'b01, init_val(3)}) begin errors++; $display("FAIL single_latency got %b/%h want 01/%h", g_rv, g_rd, init_val(3)); end
            end
        end
    endtask

    task automatic test_write_read();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        req_valid = 2'b10; set_cmd(1, 1'b1, 5, 8'hff);
        for (int k = 0; k < 5; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            if (k == 0) begin req_valid = 2'b01; set_cmd(0, 1'b0, 5, 0); end
            else req_valid = '0;
            checks++; if (g_rdy !== e_rdy) begin errors++; $display("FAIL wr_rd_ready c%0d got %b want %b", k, g_rdy, e_rdy); end
            checks++; if ({g_rv, g_rd} !== {e_rv, e_rd}) begin errors++; $display("FAIL wr_rd_rsp c%0d got %b/%h want %b/%h", k, g_rv, g_rd, e_rv, e_rd); end
            if (k == 3) begin
                checks++; if ({g_rv[0], g_rd} !== {1'b1, 8'hff}) begin errors++; $display("FAIL wr_rd_data got %b/%h want 1/ff", g_rv[0], g_rd); end
            end
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        int n_rsp [NR];
        do_reset();
        for (int i = 0; i < NR; i++) begin n_rsp[i] = 0; set_cmd(i, 1'b0, $urandom_range(0, 15), 0); end
        req_valid = '1;
        for (int k = 0; k < 18; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            for (int i = 0; i < NR; i++) begin
                if (g_rv[i]) n_rsp[i]++;
                if (e_rdy[i]) set_cmd(i, 1'b0, $urandom_range(0, 15), 0);
            end
            if (k >= 15) req_valid = '0;
            checks++; if ({g_rv, g_rd} !== {e_rv, e_rd}) begin errors++; $display("FAIL cont_rsp c%0d got %b/%h want %b/%h", k, g_rv, g_rd, e_rv, e_rd); end
            if (k < 16) begin
                checks++; if (g_rdy !== (NR'(1) << ((k / MB) % 2))) begin errors++; $display("FAIL cont_order c%0d got %b want %b", k, g_rdy, NR'(1) << ((k / MB) % 2)); end
            end
        end
        for (int i = 0; i < NR; i++) begin
            checks++; if (n_rsp[i] != 8) begin errors++; $display("FAIL cont_count r%0d got %0d want 8", i, n_rsp[i]); end
        end
    endtask

    task automatic test_lone();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        int n_acc = 0, n_rsp = 0;
        req_valid = 2'b10; set_cmd(1, 1'b0, $urandom_range(0, 15), 0);
        for (int k = 0; k < 12; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            if (k < 10 && g_rdy == 2'b10) n_acc++;
            if (g_rv[1]) n_rsp++;
            if (k >= 9) req_valid = '0;
            else set_cmd(1, 1'b0, $urandom_range(0, 15), 0);
            checks++; if ({g_rdy, g_rv, g_rd} !== {e_rdy, e_rv, e_rd}) begin errors++; $display("FAIL lone c%0d got %b/%b/%h want %b/%b/%h", k, g_rdy, g_rv, g_rd, e_rdy, e_rv, e_rd); end
        end
        checks++; if (n_acc != 10) begin errors++; $display("FAIL lone_accepts got %0d want 10", n_acc); end
        checks++; if (n_rsp != 10) begin errors++; $display("FAIL lone_responses got %0d want 10", n_rsp); end
    endtask

    task automatic test_wrack();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        req_valid = 2'b01; set_cmd(0, 1'b1, 9, 8'h5a);
        for (int k = 0; k < 4; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            req_valid = '0;
            checks++; if ({g_rdy, g_rv, g_rd} !== {e_rdy, e_rv, e_rd}) begin errors++; $display("FAIL wrack c%0d got %b/%b/%h want %b/%b/%h", k, g_rdy, g_rv, g_rd, e_rdy, e_rv, e_rd); end
            if (k == 2) begin
                checks++; if ({g_rv[0], g_rd} !== {WRACK, 8'h00}) begin errors++; $display("FAIL wrack_strobe got %b/%h want %b/00", g_rv[0], g_rd, WRACK); end
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        for (int k = 0; k < 400; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            // Requesters hold their command until accepted, then may change it.
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || e_rdy[i]) begin
                    req_valid[i] = (k < 396) && ($urandom_range(0, 3) != 0);
                    set_cmd(i, $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 255));
                end
            end
            checks++; if (g_rdy !== e_rdy) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", k, g_rdy, e_rdy); end
            checks++; if ({g_rv, g_rd} !== {e_rv, e_rd}) begin errors++; $display("FAIL rand_rsp c%0d got %b/%h want %b/%h", k, g_rv, g_rd, e_rv, e_rd); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_read();
        logic [NR-1:0] g_rdy, e_rdy, g_rv, e_rv; logic [W-1:0] g_rd, e_rd;
        req_valid = 2'b01; set_cmd(0, 1'b0, 7, 0);
        run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
        checks++; if (g_rdy !== e_rdy) begin errors++; $display("FAIL mid_accept got %b want %b", g_rdy, e_rdy); end
        reset = 1'b1; clear_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({rsp_valid, rsp_data} !== '0) begin errors++; $display("FAIL mid_rsp c%0d got %b/%h want 0/0", k, rsp_valid, rsp_data); end
        end
        checks++; if ({req_ready, ram_enable, ram_wr_en, ram_address, ram_data_in} !== '0) begin errors++; $display("FAIL mid_outputs got %b/%b/%b/%h/%h want 0", req_ready, ram_enable, ram_wr_en, ram_address, ram_data_in); end
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            run_cycle(g_rdy, e_rdy, g_rv, e_rv, g_rd, e_rd);
            checks++; if ({g_rdy, g_rv, g_rd} !== {e_rdy, e_rv, e_rd}) begin errors++; $display("FAIL mid_after c%0d got %b/%b/%h want %b/%b/%h", k, g_rdy, g_rv, g_rd, e_rdy, e_rv, e_rd); end
        end
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < (1 << D); i++) m_mem[i] = init_val(i);
        model_reset();
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_lone();
        test_wrack();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
